// File: rtl/display_mux_scheduler.sv
// rtl/display_mux_scheduler.sv - dual seven-segment scan sequencer with blanking and frame-atomic digit updates
module display_mux_scheduler #(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_valid,
    input  logic [7:0] upd_digits,
    output logic       upd_ready,
    output logic       enable,
    output logic       blank,
    output logic [3:0] hex,
    output logic       frame_done
);

    localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_LEN + 1);
    localparam int BLANK_M1 = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_M1);
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    // The frame ends on the last cycle of the final state of the scan sequence.
    localparam state_t LAST_STATE = HAS_BLANK ? BLANK1 : SHOW1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    active, active_nxt;
    logic [7:0]    pending, pending_nxt;
    logic          pend_flag, pend_flag_nxt;
    logic          boundary;
    logic          accept;
    logic          enable_nxt;
    logic          blank_nxt;
    logic [3:0]    hex_nxt;
    logic          frame_done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SHOW0;
            cnt        <= DWELL_LOAD;
            active     <= 8'h00;
            pending    <= 8'h00;
            pend_flag  <= 1'b0;
            enable     <= 1'b0;
            blank      <= 1'b0;
            hex        <= 4'h0;
            frame_done <= 1'b0;
            upd_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            active     <= active_nxt;
            pending    <= pending_nxt;
            pend_flag  <= pend_flag_nxt;
            enable     <= enable_nxt;
            blank      <= blank_nxt;
            hex        <= hex_nxt;
            frame_done <= frame_done_nxt;
            upd_ready  <= ~pend_flag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (cnt == '0) begin
            case (state)
                SHOW0: begin
                    if (HAS_BLANK) begin
                        state_nxt = BLANK0;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        state_nxt = SHOW1;
                        cnt_nxt   = DWELL_LOAD;
                    end
                end
                BLANK0: begin
                    state_nxt = SHOW1;
                    cnt_nxt   = DWELL_LOAD;
                end
                SHOW1: begin
                    if (HAS_BLANK) begin
                        state_nxt = BLANK1;
                        cnt_nxt   = BLANK_LOAD;
                    end else begin
                        state_nxt = SHOW0;
                        cnt_nxt   = DWELL_LOAD;
                    end
                end
                default: begin
                    state_nxt = SHOW0;
                    cnt_nxt   = DWELL_LOAD;
                end
            endcase
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Commit needs a held update and accept needs none, so both never fire together;
    // an accept on the boundary cycle therefore waits a full frame.
    always_comb begin
        boundary      = (cnt == '0) && (state == LAST_STATE);
        accept        = upd_valid && !pend_flag;
        active_nxt    = active;
        pending_nxt   = pending;
        pend_flag_nxt = pend_flag;
        if (boundary && pend_flag) begin
            active_nxt    = pending;
            pend_flag_nxt = 1'b0;
        end else if (accept) begin
            pending_nxt   = upd_digits;
            pend_flag_nxt = 1'b1;
        end
    end

    always_comb begin
        enable_nxt     = (state_nxt == SHOW1) || (state_nxt == BLANK1);
        blank_nxt      = (state_nxt == BLANK0) || (state_nxt == BLANK1);
        hex_nxt        = enable_nxt ? active_nxt[7:4] : active_nxt[3:0];
        frame_done_nxt = (cnt_nxt == '0) && (state_nxt == LAST_STATE);
    end

endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb/tb_display_mux_scheduler.sv - randomized bench for display_mux_scheduler against a frame-position model
module tb_display_mux_scheduler;

    localparam int D = 4;
    localparam int BL0 = 2;
    localparam int BL1 = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] upd_valid;
    logic [7:0] upd_digits [2];
    logic [1:0] upd_ready;
    logic [1:0] enable;
    logic [1:0] blank;
    logic [3:0] hex [2];
    logic [1:0] frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    int       k [2];
    bit [7:0] act [2];
    bit [7:0] pend_d [2];
    bit       pf [2];
    bit       offering [2];
    int       mode;
    bit [7:0] dq_data [$];
    int       dq_at [$];

    always #5 clk = ~clk;

    display_mux_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(BL0)) u_blank (
        .clk(clk), .reset(reset), .upd_valid(upd_valid[0]), .upd_digits(upd_digits[0]),
        .upd_ready(upd_ready[0]), .enable(enable[0]), .blank(blank[0]), .hex(hex[0]),
        .frame_done(frame_done[0])
    );

    display_mux_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(BL1)) u_noblank (
        .clk(clk), .reset(reset), .upd_valid(upd_valid[1]), .upd_digits(upd_digits[1]),
        .upd_ready(upd_ready[1]), .enable(enable[1]), .blank(blank[1]), .hex(hex[1]),
        .frame_done(frame_done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int half_len(input int i);
        return D + ((i == 0) ? BL0 : BL1);
    endfunction

    // Expected outputs follow from the cycle's position within the frame.
    task automatic check_cycle(input int i);
        int  h = half_len(i);
        int  p = k[i] % (2 * h);
        bit  e_en = (p >= h);
        bit  e_bl = ((p % h) >= D);
        bit  e_fd = (p == 2 * h - 1);
        bit [3:0] e_hex = e_en ? act[i][7:4] : act[i][3:0];
        check($sformatf("u%0d.enable@%0d", i, k[i]), 32'(enable[i]), 32'(e_en));
        check($sformatf("u%0d.blank@%0d", i, k[i]), 32'(blank[i]), 32'(e_bl));
        check($sformatf("u%0d.hex@%0d", i, k[i]), 32'(hex[i]), 32'(e_hex));
        check($sformatf("u%0d.frame_done@%0d", i, k[i]), 32'(frame_done[i]), 32'(e_fd));
        check($sformatf("u%0d.upd_ready@%0d", i, k[i]), 32'(upd_ready[i]), 32'(!pf[i]));
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.u%0d.enable", tag, i), 32'(enable[i]), 32'd0);
            check($sformatf("%s.u%0d.blank", tag, i), 32'(blank[i]), 32'd0);
            check($sformatf("%s.u%0d.hex", tag, i), 32'(hex[i]), 32'd0);
            check($sformatf("%s.u%0d.frame_done", tag, i), 32'(frame_done[i]), 32'd0);
            check($sformatf("%s.u%0d.upd_ready", tag, i), 32'(upd_ready[i]), 32'd1);
        end
    endtask

    task automatic drive(input int i);
        if (offering[i]) return;
        upd_valid[i] = 1'b0;
        if (i == 0 && mode == 0) begin
            if (dq_data.size() > 0 && k[0] >= dq_at[0]) begin
                upd_digits[0] = dq_data.pop_front();
                void'(dq_at.pop_front());
                upd_valid[0]  = 1'b1;
                offering[0]   = 1'b1;
            end
        end else if (i == 0 && mode == 2) begin
            upd_valid[0] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            upd_digits[i] = 8'($urandom);
            upd_valid[i]  = 1'b1;
            offering[i]   = 1'b1;
        end
    endtask

    task automatic model_clock(input int i);
        int  h = half_len(i);
        bit  at_boundary = ((k[i] % (2 * h)) == 2 * h - 1);
        if (at_boundary && pf[i]) begin
            act[i] = pend_d[i];
            pf[i]  = 1'b0;
        end else if (upd_valid[i] && !pf[i]) begin
            pend_d[i]   = upd_digits[i];
            pf[i]       = 1'b1;
            offering[i] = 1'b0;
        end
        k[i]++;
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) check_cycle(i);
        for (int i = 0; i < 2; i++) drive(i);
        for (int i = 0; i < 2; i++) model_clock(i);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; act[i] = 8'h00; pend_d[i] = 8'h00; pf[i] = 1'b0; offering[i] = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b0;
        upd_valid     = 2'b00;
        upd_digits[0] = 8'h00;
        upd_digits[1] = 8'h00;
        model_reset();
        mode = 0;
        // update commit, backpressure pair, boundary-coincident offer, then the update the reset drops
        dq_data = '{8'h3A, 8'h12, 8'h34, 8'h5C, 8'hFF};
        dq_at   = '{1, 13, 14, 47, 60};

        repeat (3) @(negedge clk);
        check_reset_values("reset_hold");
        reset = 1'b1;

        while (k[0] < 65) step();

        // mid-frame reset during BLANK0 of the blanked instance, with 8'hFF still pending
        upd_valid = 2'b00;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (3) @(negedge clk);
        check_reset_values("reset_hold2");
        model_reset();
        reset = 1'b1;

        mode = 2;
        while (k[0] < 24) step();
        mode = 1;
        while (k[0] < 600) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_mux_scheduler.md
# display_mux_scheduler

Time-multiplexing controller for the dual seven-segment display. It sequences the `two_bit_demux` select by driving its `enable` input, and presents the matching hex nibble to the shared segment decoder. It inserts blanking dead-time between digits to prevent ghosting. New digit pairs arrive through a valid/ready handshake and are committed only at frame boundaries, so a displayed frame never tears.

## Interface
- `DWELL_CYCLES`, default 24000: cycles each digit is lit (≥1).
- `BLANK_CYCLES`, default 240: dead-time cycles after each digit (≥0; 0 removes the blank states).
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `upd_valid`  in  1: a new digit pair is offered.
- `upd_digits`  in  8: `[3:0]` is digit 0 and `[7:4]` is digit 1, sampled when `upd_valid & upd_ready`.
- `upd_ready`  out  1: the block can accept an update (no update pending).
- `enable`  out  1: demux select; 0 selects digit 0, 1 selects digit 1.
- `blank`  out  1: high during dead-time; the top level gates the anode drive with `~blank`.
- `hex`  out  4: nibble for the currently selected digit.
- `frame_done`  out  1: one-cycle pulse on the last cycle of each frame.

## Operation
- FSM states, visited cyclically: SHOW0 → BLANK0 → SHOW1 → BLANK1 → SHOW0.
  - When `BLANK_CYCLES`=0 the sequence is SHOW0 → SHOW1 → SHOW0.
- Outputs per state:
  - SHOW0: `enable`=0, `blank`=0, `hex`=`active[3:0]`.
  - BLANK0: `enable`=0, `blank`=1, `hex`=`active[3:0]`.
  - SHOW1: `enable`=1, `blank`=0, `hex`=`active[7:4]`.
  - BLANK1: `enable`=1, `blank`=1, `hex`=`active[7:4]`.
- `enable` changes only while `blank`=1, except when `BLANK_CYCLES`=0.
- A single down-counter times each state:
  - Loaded with the state's length minus 1 on entry.
  - The state advances when the counter is 0.
  - Counter width is `$clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)`, with no wrap.
- Update path:
  - An accepted `upd_digits` goes into register `pending`, sets `pend_flag`, and drives `upd_ready`=0.
  - On the frame-boundary cycle (last cycle of BLANK1, or of SHOW1 when there is no blank): if `pend_flag`, then `active`<=`pending` and `pend_flag` clears.
  - `upd_ready` returns to 1 on the following cycle.
  - At most one update is held. `upd_valid` asserted while `upd_ready`=0 is ignored; the source must hold it.
- `frame_done` asserts on the frame-boundary cycle whether or not a commit occurs.
- Reset (asynchronous, `reset`=0), held until release:
  - state SHOW0, counter `DWELL_CYCLES`-1.
  - `active`=8'h00, `pending`=8'h00, `pend_flag`=0.
  - `enable`=0, `blank`=0, `hex`=0, `frame_done`=0, `upd_ready`=1.
  - A mid-frame reset discards any pending update.

## Timing
- All outputs are registered Moore outputs, valid the cycle the state register holds the state.
- Frame length is 2·(`DWELL_CYCLES`+`BLANK_CYCLES`) cycles. The first SHOW0 after reset release lasts exactly `DWELL_CYCLES` cycles.
- Handshake latency:
  - Accept at cycle t gives `upd_ready`=0 from t+1.
  - The commit becomes visible on `hex` at the first SHOW0 of the next frame, i.e. the cycle after `frame_done`.
- If the accept cycle coincides with the frame-boundary cycle, the new data is not committed in that cycle; it commits at the next boundary.
- `upd_ready`, `frame_done` and `blank` never glitch; each changes only on a rising `clk` edge.

## Test plan
All scenarios use `DWELL_CYCLES`=4, `BLANK_CYCLES`=2 (12-cycle frame) unless noted.
- **Reset/idle:** hold `reset`=0 for 3 cycles, then release. Require `enable`=0, `blank`=0, `hex`=0, `upd_ready`=1. Then the pattern (`enable`,`blank`) = 0,0 ×4; 0,1 ×2; 1,0 ×4; 1,1 ×2, repeating. `frame_done` is high only on cycle 12.
- **Update commit:** offer `upd_digits`=8'h3A in cycle 2 of SHOW0.
  - `upd_ready`=0 from the next cycle.
  - `hex` stays 0 for the rest of the frame.
  - The next SHOW0 shows `hex`=4'hA, and SHOW1 shows 4'h3.
  - `upd_ready`=1 one cycle after `frame_done`.
- **Backpressure:** offer 8'h12, then 8'h34 while `upd_ready`=0, holding `upd_valid`. Frame 2 shows 2/1 and frame 3 shows 4/3; no data is lost or duplicated.
- **Boundary coincidence:** offer 8'h5C exactly on the `frame_done` cycle. It is not shown in the next frame; it is shown in the frame after.
- **Mid-frame reset:** accept 8'hFF, then assert `reset` during BLANK0. All outputs return to reset values at once, asynchronously, and after release `hex` stays 0 (the pending update is dropped).
- **No blanking:** with `BLANK_CYCLES`=0, `blank` is never 1, `enable` toggles every 4 cycles, and `frame_done` fires every 8 cycles.
